// File: rtl/phase_sequencer.sv
// -----------------------------------------------------------------------------
// phase_sequencer
//
// Locks to the adiabatic power clock seen through the phase detector output
// and, once locked, produces a one-hot 4-phase enable, one quarter period per
// phase, for the downstream adiabatic logic stages.
//
// Flow: det_in -> 2-flop synchroniser -> (optional glitch filter) -> rising
// edge detect. Each rising edge captures the free-running period counter.
// Consecutive in-tolerance periods lock the sequencer. While locked, a period
// drift beyond TOL or a missing edge for TIMEOUT cycles raises a fault that
// holds until clr_fault.
//
// Optional feature macro: PHASE_SEQ_GLITCH_FILTER_EN
//   Defined   : the synchronised level only changes after it has held a new
//               value for 3 consecutive cycles (rise latency +2 cycles,
//               1-2 cycle pulses on det_in are ignored).
//   Undefined : every synchronised transition counts.
//
// Ports:
//   clk        in   system clock
//   rst_n      in   asynchronous active-low reset
//   det_in     in   phase detector output, asynchronous to clk
//   clr_fault  in   single-cycle pulse, leaves FAULT for IDLE
//   phase_en   out  [3:0] one-hot phase enable, zero unless locked
//   phase_idx  out  [1:0] current phase index
//   locked     out  high in LOCKED
//   fault      out  high in FAULT
//   period     out  [CNT_W-1:0] locked period in clk cycles
// -----------------------------------------------------------------------------
module phase_sequencer #(
    parameter int CNT_W    = 12,
    parameter int LOCK_CNT = 4,
    parameter int TOL      = 2,
    parameter int TIMEOUT  = 4000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             det_in,
    input  logic             clr_fault,
    output logic [3:0]       phase_en,
    output logic [1:0]       phase_idx,
    output logic             locked,
    output logic             fault,
    output logic [CNT_W-1:0] period
);

    localparam int               LW        = $clog2(LOCK_CNT + 1);
    localparam logic [CNT_W-1:0] TOL_C     = CNT_W'(TOL);
    localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] MIN_PER_C = CNT_W'(4);
    localparam logic [LW-1:0]    LOCK_C    = LW'(LOCK_CNT);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ACQUIRE = 2'd1,
        S_LOCKED  = 2'd2,
        S_FAULT   = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic             sync1_q, det_s_q, det_q;
    logic             det_f, rise;
    logic [CNT_W-1:0] pcnt_q, pcnt_d;
    logic [CNT_W-1:0] pcur_q, pcur_d;
    logic             have_prev_q, have_prev_d;
    logic [LW-1:0]    lock_cnt_q, lock_cnt_d, lock_inc;
    logic [CNT_W-1:0] period_q, period_d;
    logic [CNT_W-1:0] sub_q, sub_d;
    logic [1:0]       idx_q, idx_d;
    logic [3:0]       phase_en_q, phase_en_d;
    logic [CNT_W-1:0] quarter_raw, quarter;
    logic             timeout;

    function automatic logic in_tol(input logic [CNT_W-1:0] a,
                                    input logic [CNT_W-1:0] b);
        logic [CNT_W-1:0] diff;
        diff = (a >= b) ? (a - b) : (b - a);
        return (diff <= TOL_C);
    endfunction

    // Synchroniser; det_q holds the previous (filtered) level for edge detect.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b0;
            det_s_q <= 1'b0;
            det_q   <= 1'b0;
        end else begin
            sync1_q <= det_in;
            det_s_q <= sync1_q;
            det_q   <= det_f;
        end
    end

`ifdef PHASE_SEQ_GLITCH_FILTER_EN
    logic hist1_q, hist2_q, filt_q;

    // The level follows det_s only once the current and two previous samples agree.
    assign det_f = (det_s_q == hist1_q && hist1_q == hist2_q) ? det_s_q : filt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hist1_q <= 1'b0;
            hist2_q <= 1'b0;
            filt_q  <= 1'b0;
        end else begin
            hist1_q <= det_s_q;
            hist2_q <= hist1_q;
            filt_q  <= det_f;
        end
    end
`else
    assign det_f = det_s_q;
`endif

    assign rise        = det_f & ~det_q;
    assign timeout     = (pcnt_q == TIMEOUT_C);
    assign quarter_raw = period_q >> 2;
    assign quarter     = (quarter_raw == '0) ? CNT_W'(1) : quarter_raw;
    assign lock_inc    = lock_cnt_q + LW'(1);

    always_comb begin
        state_d     = state_q;
        have_prev_d = have_prev_q;
        lock_cnt_d  = lock_cnt_q;
        period_d    = period_q;
        pcur_d      = rise ? pcnt_q : pcur_q;
        if (rise)
            pcnt_d = CNT_W'(1);
        else if (pcnt_q == '1)
            pcnt_d = pcnt_q;
        else
            pcnt_d = pcnt_q + CNT_W'(1);

        // On a rise the incoming capture (pcnt_q) is compared against the
        // previous capture still held in pcur_q.
        case (state_q)
            S_IDLE: begin
                if (rise) begin
                    state_d     = S_ACQUIRE;
                    lock_cnt_d  = '0;
                    have_prev_d = 1'b0;
                end
            end
            S_ACQUIRE: begin
                if (rise) begin
                    have_prev_d = 1'b1;
                    if (have_prev_q) begin
                        if (in_tol(pcnt_q, pcur_q)) begin
                            lock_cnt_d = lock_inc;
                            if (lock_inc == LOCK_C) begin
                                if (pcnt_q < MIN_PER_C) begin
                                    state_d = S_FAULT;
                                end else begin
                                    state_d  = S_LOCKED;
                                    period_d = pcnt_q;
                                end
                            end
                        end else begin
                            lock_cnt_d = '0;
                        end
                    end
                end else if (timeout) begin
                    state_d = S_IDLE;
                end
            end
            S_LOCKED: begin
                if (rise) begin
                    if (!in_tol(pcnt_q, period_q))
                        state_d = S_FAULT;
                end else if (timeout) begin
                    state_d = S_FAULT;
                end
            end
            S_FAULT: begin
                if (clr_fault) begin
                    state_d  = S_IDLE;
                    period_d = '0;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Phase generation: quarter-period sub-counter, index saturates at 3
        // until the next rise realigns it.
        sub_d = '0;
        idx_d = 2'd0;
        if (state_d == S_LOCKED && !rise) begin
            if (sub_q == quarter - CNT_W'(1)) begin
                sub_d = '0;
                idx_d = (idx_q == 2'd3) ? 2'd3 : idx_q + 2'd1;
            end else begin
                sub_d = sub_q + CNT_W'(1);
                idx_d = idx_q;
            end
        end
        phase_en_d = (state_d == S_LOCKED) ? (4'b0001 << idx_d) : 4'b0000;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            pcnt_q      <= '0;
            pcur_q      <= '0;
            have_prev_q <= 1'b0;
            lock_cnt_q  <= '0;
            period_q    <= '0;
            sub_q       <= '0;
            idx_q       <= 2'd0;
            phase_en_q  <= 4'b0000;
        end else begin
            state_q     <= state_d;
            pcnt_q      <= pcnt_d;
            pcur_q      <= pcur_d;
            have_prev_q <= have_prev_d;
            lock_cnt_q  <= lock_cnt_d;
            period_q    <= period_d;
            sub_q       <= sub_d;
            idx_q       <= idx_d;
            phase_en_q  <= phase_en_d;
        end
    end

    assign phase_en  = phase_en_q;
    assign phase_idx = idx_q;
    assign locked    = (state_q == S_LOCKED);
    assign fault     = (state_q == S_FAULT);
    assign period    = period_q;

endmodule

// File: tb/tb_phase_sequencer.sv
// -----------------------------------------------------------------------------
// tb_phase_sequencer
//
// Drives det_in square waves (directed and randomized) into phase_sequencer
// and compares every cycle against a behavioural model that works on edge
// times: rises are derived from the sampled input history, periods are
// differences of rise times, and the phase index is elapsed-time / quarter.
// A few literal expectations pin the model to hand-computed values.
// -----------------------------------------------------------------------------
module tb_phase_sequencer;

    localparam int CNT_W    = 12;
    localparam int LOCK_CNT = 4;
    localparam int TOL      = 2;
    localparam int TIMEOUT  = 4000;
    localparam int CNT_MAX  = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             det_in = 1'b0;
    logic             clr_fault = 1'b0;
    logic [3:0]       phase_en;
    logic [1:0]       phase_idx;
    logic             locked;
    logic             fault;
    logic [CNT_W-1:0] period;

    int total = 0;
    int bad   = 0;

    phase_sequencer #(
        .CNT_W   (CNT_W),
        .LOCK_CNT(LOCK_CNT),
        .TOL     (TOL),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .det_in   (det_in),
        .clr_fault(clr_fault),
        .phase_en (phase_en),
        .phase_idx(phase_idx),
        .locked   (locked),
        .fault    (fault),
        .period   (period)
    );

    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    // m_st: 0 idle, 1 acquire, 2 locked, 3 fault
    int m_st, m_k, m_r, m_nr, m_lcnt, m_prevp, m_per;
    bit sh [4];
    bit fh [4];
    int exp_locked, exp_fault, exp_period, exp_idx, exp_en;

    function automatic int absd(input int a, input int b);
        return (a >= b) ? a - b : b - a;
    endfunction

    task automatic model_step();
        int meas;
        int q;
        bit rise;
        if (!rst_n) begin
            m_st = 0; m_k = 0; m_r = 1; m_nr = 0; m_lcnt = 0; m_prevp = 0; m_per = 0;
            for (int i = 0; i < 4; i++) begin
                sh[i] = 1'b0;
                fh[i] = 1'b0;
            end
        end else begin
            m_k++;
            for (int i = 3; i > 0; i--) begin
                sh[i] = sh[i-1];
                fh[i] = fh[i-1];
            end
            sh[0] = det_in;
`ifdef PHASE_SEQ_GLITCH_FILTER_EN
            fh[0] = (sh[0] == sh[1] && sh[1] == sh[2]) ? sh[0] : fh[1];
`else
            fh[0] = sh[0];
`endif
            rise = fh[2] && !fh[3];
            meas = m_k - m_r;
            if (meas > CNT_MAX) meas = CNT_MAX;
            case (m_st)
                0: if (rise) begin
                    m_st = 1; m_nr = 0; m_lcnt = 0;
                end
                1: if (rise) begin
                    if (m_nr >= 1) begin
                        if (absd(meas, m_prevp) <= TOL) m_lcnt++;
                        else m_lcnt = 0;
                        if (m_lcnt == LOCK_CNT) begin
                            if (meas < 4) m_st = 3;
                            else begin
                                m_st = 2;
                                m_per = meas;
                            end
                        end
                    end
                    m_prevp = meas;
                    m_nr++;
                end else if (meas == TIMEOUT) begin
                    m_st = 0;
                end
                2: if (rise) begin
                    if (absd(meas, m_per) > TOL) m_st = 3;
                end else if (meas == TIMEOUT) begin
                    m_st = 3;
                end
                default: if (clr_fault) begin
                    m_st = 0;
                    m_per = 0;
                end
            endcase
            if (rise) m_r = m_k;
        end
        exp_locked = (m_st == 2) ? 1 : 0;
        exp_fault  = (m_st == 3) ? 1 : 0;
        exp_period = m_per;
        exp_idx    = 0;
        if (m_st == 2) begin
            q = (m_per / 4 < 1) ? 1 : m_per / 4;
            exp_idx = (m_k - m_r) / q;
            if (exp_idx > 3) exp_idx = 3;
        end
        exp_en = (m_st == 2) ? (1 << exp_idx) : 0;
    endtask

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    initial forever begin
        @(posedge clk);
        #1;
        check("cyc_locked", int'(locked), exp_locked);
        check("cyc_fault", int'(fault), exp_fault);
        check("cyc_period", int'(period), exp_period);
        check("cyc_phase_idx", int'(phase_idx), exp_idx);
        check("cyc_phase_en", int'(phase_en), exp_en);
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("test done: total=%0d bad=%0d", total, bad + 1);
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus helpers ----------------
    task automatic wait_n(input int n);
        repeat (n) @(negedge clk);
    endtask

    // One det_in period: high for p/2, low for the rest, optional high glitch
    // of width gw in the middle of the low part.
    task automatic drive_period(input int p, input int gw);
        int hi;
        int lo;
        int off;
        hi = p / 2;
        lo = p - hi;
        off = lo / 2;
        det_in = 1'b1;
        wait_n(hi);
        for (int i = 0; i < lo; i++) begin
            det_in = (gw > 0 && lo >= 8 && i >= off && i < off + gw);
            @(negedge clk);
        end
        det_in = 1'b0;
    endtask

    task automatic pulse_clr();
        clr_fault = 1'b1;
        @(negedge clk);
        clr_fault = 1'b0;
        @(negedge clk);
    endtask

    task automatic pulse_rst();
        rst_n = 1'b0;
        wait_n(3);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    int pc [4];

    initial begin
        int base;
        int p;
        int gw;
        @(negedge clk);

        // Reset held while det_in toggles
        for (int i = 0; i < 10; i++) begin
            det_in = ~det_in;
            @(negedge clk);
        end
        check("rst_locked", int'(locked), 0);
        check("rst_fault", int'(fault), 0);
        check("rst_phase_en", int'(phase_en), 0);
        check("rst_phase_idx", int'(phase_idx), 0);
        check("rst_period", int'(period), 0);
        det_in = 1'b0;
        rst_n = 1'b1;
        wait_n(5);

        // Clean lock at 100: not locked before the 6th rise, locked after
        repeat (5) drive_period(100, 0);
        check("lock_before_6th", int'(locked), 0);
        repeat (3) drive_period(100, 0);
        check("lock_after_6th", int'(locked), 1);
        check("lock_period", int'(period), 100);

        // 400 steady cycles: 100 in each phase
        for (int i = 0; i < 4; i++) pc[i] = 0;
        fork
            repeat (4) drive_period(100, 0);
            begin
                for (int i = 0; i < 400; i++) begin
                    @(posedge clk);
                    #1;
                    for (int j = 0; j < 4; j++)
                        if (phase_en == 4'(1 << j)) pc[j]++;
                end
            end
        join
        check("phase0_cycles", pc[0], 100);
        check("phase1_cycles", pc[1], 100);
        check("phase2_cycles", pc[2], 100);
        check("phase3_cycles", pc[3], 100);

        // Drift: one period of 97
        drive_period(97, 0);
        repeat (2) drive_period(100, 0);
        check("drift_fault", int'(fault), 1);
        check("drift_phase_en", int'(phase_en), 0);
        pulse_clr();
        check("clr_fault_low", int'(fault), 0);
        check("clr_period", int'(period), 0);
        repeat (8) drive_period(97, 0);
        check("relock97", int'(locked), 1);
        check("relock97_period", int'(period), 97);

        // Jitter 100/102 locks; 100/104 never does
        pulse_rst();
        repeat (4) begin
            drive_period(100, 0);
            drive_period(102, 0);
        end
        check("jit2_locked", int'(locked), 1);
        check("jit2_period", int'(period), 100);
        pulse_rst();
        repeat (5) begin
            drive_period(100, 0);
            drive_period(104, 0);
        end
        check("jit4_locked", int'(locked), 0);

        // Stall in ACQUIRE: back to IDLE, no fault
        wait_n(4100);
        check("acq_stall_fault", int'(fault), 0);
        check("acq_stall_locked", int'(locked), 0);

        // Stall while LOCKED: fault once pcnt reaches TIMEOUT
        repeat (8) drive_period(100, 0);
        check("pre_stall_locked", int'(locked), 1);
        wait_n(3850);
        check("stall_early_fault", int'(fault), 0);
        wait_n(100);
        check("stall_fault", int'(fault), 1);
        pulse_clr();

        // Glitches while locked
        repeat (8) drive_period(100, 0);
        drive_period(100, 1);
        drive_period(100, 2);
        repeat (2) drive_period(100, 0);
`ifdef PHASE_SEQ_GLITCH_FILTER_EN
        check("glitch_locked", int'(locked), 1);
        check("glitch_fault", int'(fault), 0);
`else
        check("glitch_locked", int'(locked), 0);
        check("glitch_fault", int'(fault), 1);
`endif
        pulse_clr();

        // Randomized periods, jitter, glitches and clear pulses
        for (int b = 0; b < 10; b++) begin
            base = $urandom_range(12, 120);
            for (int i = 0; i < 8; i++) begin
                p  = base + $urandom_range(0, 3);
                gw = ($urandom_range(0, 9) == 0) ? $urandom_range(1, 2) : 0;
                drive_period(p, gw);
            end
            if ($urandom_range(0, 1) == 1) pulse_clr();
        end

        wait_n(5);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/phase_sequencer.md
Name: phase_sequencer

Overview:
- Consumes the phase detector's digital output `det_in`, which is a logic-level, inverted image of the adiabatic power-clock phase and is asynchronous to `clk`.
- Synchronises `det_in`, measures the power-clock period in `clk` cycles and locks to it.
- Once locked, emits a one-hot 4-phase enable (quarter periods) that drives the downstream adiabatic logic stages.
- Flags a fault when the period drifts or the power clock stops.

Parameters:
- CNT_W, 12: width of the period counter and the captured period registers.
- LOCK_CNT, 4: number of consecutive in-tolerance periods required to lock.
- TOL, 2: allowed absolute period deviation, in `clk` cycles.
- TIMEOUT, 4000: cycles with no rising edge before a timeout; must be < 2^CNT_W.

Ports:
- clk, input, 1: system clock.
- rst_n, input, 1: reset, asynchronous, active-low.
- det_in, input, 1: phase detector output, asynchronous to `clk`.
- clr_fault, input, 1: single-cycle pulse; clears FAULT.
- phase_en, output, 4: one-hot phase enable; all zeros unless locked.
- phase_idx, output, 2: current phase index 0..3.
- locked, output, 1: high in state LOCKED.
- fault, output, 1: high in state FAULT.
- period, output, CNT_W: locked period in `clk` cycles.

Behaviour:
- Reset:
  - Asynchronous, active-low `rst_n`; all flops clear.
  - State = IDLE.
  - `phase_en` = 0, `phase_idx` = 0, `locked` = 0, `fault` = 0, `period` = 0.
  - Synchroniser flops = 0.
  - `rst_n` asserted mid-operation aborts immediately to these values.
- Synchroniser:
  - Two-flop synchroniser on `det_in` produces `det_s`; `det_q` is `det_s` delayed one cycle.
  - `rise = det_s & ~det_q`.
  - A 0->1 level on `det_in` that is stable before edge N gives `rise` high in the cycle after edge N+1.
- Period counter `pcnt`:
  - Increments every cycle and saturates at all-ones.
  - On `rise`: `pcnt` is captured into `pcur`, the previous `pcur` moves to `pprev`, and `pcnt` loads 1.
- FSM:
  - IDLE: first `rise` -> ACQUIRE; `lock_cnt` = 0; `pcnt` restarts.
  - ACQUIRE, on each `rise` with a valid `pprev`:
    - If |pcur - pprev| <= TOL, `lock_cnt++`; otherwise `lock_cnt` = 0.
    - When `lock_cnt` reaches LOCK_CNT, go to LOCKED and latch `period` = `pcur`.
    - If `pcnt` reaches TIMEOUT, go to IDLE.
  - LOCKED:
    - On `rise`, if |pcur - period| > TOL, go to FAULT.
    - If `pcnt` reaches TIMEOUT, go to FAULT.
    - `period` is not updated while locked; no tracking.
  - FAULT:
    - Holds until `clr_fault`, then goes to IDLE and clears `period` to 0.
    - `clr_fault` in any other state is ignored.
- Phase generation, active in LOCKED only:
  - `quarter = period >> 2`; minimum 1. If `period` < 4, treat as fault on entry: go to FAULT instead of LOCKED.
  - A sub-counter restarts at 0 on `rise`, increments each cycle, and wraps at `quarter - 1`, advancing `phase_idx`.
  - `phase_idx` saturates at 3; it does not wrap until the next `rise`.
  - `rise` forces `phase_idx` = 0 in the same cycle it is registered.
  - `phase_en = 1 << phase_idx` while `locked`; otherwise 0.
  - Outputs are registered, so `phase_en` reflects `phase_idx` with no extra latency.
- Simultaneous events:
  - `rise` in the same cycle that `pcnt` reaches TIMEOUT: `rise` wins.
  - `clr_fault` together with `rise` in FAULT: go to IDLE; that `rise` is not counted.

Optional Feature:
- Macro: PHASE_SEQ_GLITCH_FILTER_EN.
- Defined:
  - After the synchroniser, `det_s` is replaced by a filtered level that changes only after the synchronised input holds its new value for 3 consecutive cycles.
  - Adds 2 cycles of `rise` latency.
  - Pulses of 1-2 cycles on `det_in` are ignored.
- Undefined: no filter; every synchronised transition counts.

Test Plan:
- Reset: `rst_n` = 0 with `det_in` toggling -> all outputs 0, state IDLE. Release `rst_n` -> no `rise` until the 2-flop delay has passed.
- Clean lock: `det_in` square wave with period 100 `clk`, LOCK_CNT = 4 -> `locked` = 1 after the 6th `rise`, `period` = 100. Then `phase_en` = 0001, 0010, 0100, 1000 for 25 cycles each, repeating.
- Jitter: periods alternate 100/102 -> locks (within TOL). Periods alternate 100/104 -> `lock_cnt` resets each time and `locked` never asserts.
- Drift fault: lock at 100, then one period of 97 -> `fault` = 1, `phase_en` = 0. `clr_fault` pulse -> IDLE, `period` = 0; relock at 97.
- Timeout: lock at 100, then hold `det_in` = 0 -> FAULT exactly when `pcnt` reaches 4000. In ACQUIRE, the same stall -> IDLE with `fault` = 0.
- Glitch filter, with the macro defined: 1-cycle and 2-cycle high pulses on `det_in` during LOCKED -> no `rise`, stays locked. Without the macro, the same pulse -> FAULT.
